jump_pulse_gen: RTL and testbench

JUMP_PULSE_GEN -- requirements
Module: jump_pulse_gen

---
 rtl/jump_pkg.sv | 17 +
 rtl/sync_2ff.sv | 25 ++
 rtl/jump_pulse_gen.sv | 129 ++++++++++++
 tb/tb_jump_pulse_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// Shared definitions for the jump pulse generator: FSM state encoding,
// counter width and default timing constants.
package jump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_e;

  localparam int unsigned CNT_W               = 16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES     = 50;
  localparam int unsigned DEF_REPEAT_CYCLES   = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; the first flop
// feeds only the second so it has a full cycle to resolve metastability.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/jump_pulse_gen.sv
// Debounces a raw key and emits a one-cycle jump pulse per accepted press,
// with optional auto-repeat while the key stays held.
module jump_pulse_gen
  import jump_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       jump,
  output logic       key_level,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

  logic             key_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_phase_q, rep_phase_d;
  logic [CNT_W-1:0] rep_target_s;
  logic             accept_s;
  logic             fire_s;
  logic             jump_q;
  logic             key_level_q;
  logic [7:0]       press_cnt_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rep_cnt_d    = rep_cnt_q;
    rep_phase_d  = rep_phase_q;
    accept_s     = 1'b0;
    fire_s       = 1'b0;
    rep_target_s = rep_phase_q ? REP_LAST : HOLD_LAST;
    case (state_q)
      ST_IDLE: begin
        if (key_s) begin
          state_d = ST_PRESS_DB;
          cnt_d   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!key_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d     = ST_PRESSED;
          accept_s    = 1'b1;
          rep_cnt_d   = '0;
          rep_phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_PRESSED: begin
        if (!key_s) begin
          state_d     = ST_RELEASE_DB;
          cnt_d       = '0;
          rep_cnt_d   = '0;
          rep_phase_d = 1'b0;
        end else if (REPEAT_EN) begin
          // first interval is the hold time, later ones the repeat period
          if (rep_cnt_q == rep_target_s) begin
            fire_s      = !jump_q;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 16'd1;
          end
        end else begin
          rep_cnt_d = '0;
        end
      end
      ST_RELEASE_DB: begin
        if (key_s) begin
          state_d     = ST_PRESSED;
          rep_cnt_d   = '0;
          rep_phase_d = 1'b0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      jump_q      <= 1'b0;
      key_level_q <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      jump_q      <= accept_s | fire_s;
      key_level_q <= (state_d == ST_PRESSED) || (state_d == ST_RELEASE_DB);
      press_cnt_q <= press_cnt_q + {7'd0, accept_s};
    end
  end

  assign jump      = jump_q;
  assign key_level = key_level_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_jump_pulse_gen.sv
// Self-checking bench: expected jump cycles are queued when stimulus is
// driven and matched against the cycles where the DUT raises jump.
module tb_jump_pulse_gen;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic       key_r = 1'b0;
  logic       jump, key_level, jump_r, key_level_r;
  logic [7:0] press_cnt, press_cnt_r;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int dbl_cnt = 0;
  int exp_q[$];
  int obs_q[$];
  int exp_r_q[$];
  int obs_r_q[$];
  logic prev_jump = 1'b0;
  logic prev_jump_r = 1'b0;

  jump_pulse_gen dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key),
    .jump      (jump),
    .key_level (key_level),
    .press_cnt (press_cnt)
  );

  jump_pulse_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (1'b1),
    .HOLD_CYCLES     (50),
    .REPEAT_CYCLES   (10)
  ) dut_r (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_r),
    .jump      (jump_r),
    .key_level (key_level_r),
    .press_cnt (press_cnt_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record the edge index preceding every high jump cycle
  always @(negedge clk) begin
    if (jump === 1'b1) obs_q.push_back(cyc);
    if (jump_r === 1'b1) obs_r_q.push_back(cyc);
    if ((jump === 1'b1 && prev_jump === 1'b1) || (jump_r === 1'b1 && prev_jump_r === 1'b1))
      dbl_cnt++;
    prev_jump   = jump;
    prev_jump_r = jump_r;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; key = 1'b0; key_r = 1'b0;
    step(3);
    n_cmp++; if (jump !== 1'b0) begin n_bad++; $display("FAIL reset_jump: got %b want 0", jump); end
    n_cmp++; if (key_level !== 1'b0) begin n_bad++; $display("FAIL reset_level: got %b want 0", key_level); end
    n_cmp++; if (press_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", press_cnt); end
    n_cmp++; if (press_cnt_r !== 8'd0) begin n_bad++; $display("FAIL reset_cnt_r: got %0d want 0", press_cnt_r); end
    rst = 1'b0;
    step(1);
    obs_q.delete(); obs_r_q.delete();
  endtask

  task automatic test_press();
    int e, o;
    @(negedge clk);
    key = 1'b1;
    exp_q.push_back(cyc + D + 3);
    step(D + 8);
    n_cmp++; if (key_level !== 1'b1) begin n_bad++; $display("FAIL press_level: got %b want 1", key_level); end
    n_cmp++; if (press_cnt !== 8'd1) begin n_bad++; $display("FAIL press_cnt: got %0d want 1", press_cnt); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = -1; o = -1;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL press_pulse: jump at cycle %0d, expected %0d", o, e); end
    end
    key = 1'b0;
    step(D + 6);
    n_cmp++; if (key_level !== 1'b0) begin n_bad++; $display("FAIL release_level: got %b want 0", key_level); end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    key = 1'b1;
    step(2);
    key = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_cmp++; if (key_level !== 1'b0) begin n_bad++; $display("FAIL glitch_level: cycle %0d got %b want 0", cyc, key_level); end
    end
    n_cmp++; if (press_cnt !== 8'd1) begin n_bad++; $display("FAIL glitch_cnt: got %0d want 1", press_cnt); end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL glitch_pulse: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_release_glitch();
    int e, o;
    @(negedge clk);
    key = 1'b1;
    exp_q.push_back(cyc + D + 3);
    step(D + 8);
    key = 1'b0;
    step(2);
    key = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      n_cmp++; if (key_level !== 1'b1) begin n_bad++; $display("FAIL relglitch_level: cycle %0d got %b want 1", cyc, key_level); end
    end
    n_cmp++; if (press_cnt !== 8'd2) begin n_bad++; $display("FAIL relglitch_cnt: got %0d want 2", press_cnt); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = -1; o = -1;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL relglitch_pulse: jump at cycle %0d, expected %0d", o, e); end
    end
    key = 1'b0;
    step(D + 6);
  endtask

  task automatic test_reset_mid();
    int e, o;
    @(negedge clk);
    key = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL rstmid_early: got %0d pulses want 0", obs_q.size()); end
    n_cmp++; if (press_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid_cnt0: got %0d want 0", press_cnt); end
    exp_q.push_back(cyc + D + 3);
    step(D + 8);
    n_cmp++; if (press_cnt !== 8'd1) begin n_bad++; $display("FAIL rstmid_cnt1: got %0d want 1", press_cnt); end
    n_cmp++; if (key_level !== 1'b1) begin n_bad++; $display("FAIL rstmid_level: got %b want 1", key_level); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = -1; o = -1;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rstmid_pulse: jump at cycle %0d, expected %0d", o, e); end
    end
    key = 1'b0;
    step(D + 6);
  endtask

  task automatic test_repeat();
    int a, e, o;
    obs_r_q.delete();
    @(negedge clk);
    key_r = 1'b1;
    a = cyc + D + 3;
    exp_r_q.push_back(a);
    for (int k = 50; k <= 90; k += 10) exp_r_q.push_back(a + k);
    step(D + 3 + 95);
    key_r = 1'b0;
    step(D + 6);
    n_cmp++; if (press_cnt_r !== 8'd1) begin n_bad++; $display("FAIL repeat_cnt: got %0d want 1", press_cnt_r); end
    n_cmp++; if (key_level_r !== 1'b0) begin n_bad++; $display("FAIL repeat_level: got %b want 0", key_level_r); end
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL repeat_idle_dut: got %0d pulses want 0", obs_q.size()); end
    while (exp_r_q.size() != 0 || obs_r_q.size() != 0) begin
      e = -1; o = -1;
      if (exp_r_q.size() != 0) e = exp_r_q.pop_front();
      if (obs_r_q.size() != 0) o = obs_r_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL repeat_pulse: jump at cycle %0d, expected %0d", o, e); end
    end
  endtask

  task automatic test_wrap();
    int e, o;
    @(negedge clk);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 256; i++) begin
      key = 1'b1;
      exp_q.push_back(cyc + D + 3);
      step(D + 6);
      key = 1'b0;
      step(D + 6);
      if (i == 254) begin
        n_cmp++; if (press_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d want 255", press_cnt); end
      end
    end
    n_cmp++; if (press_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_0: got %0d want 0", press_cnt); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = -1; o = -1;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wrap_pulse: jump at cycle %0d, expected %0d", o, e); end
    end
    n_cmp++; if (dbl_cnt !== 0) begin n_bad++; $display("FAIL double_pulse: got %0d back-to-back pulses want 0", dbl_cnt); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_release_glitch();
    test_reset_mid();
    test_repeat();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
